uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of received bytes buffered; power of two, at least 2.
REQ-002 Port: clk  input  1  sole clock; all logic on posedge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: wen  input  1  bus write strobe.
REQ-005 Port: ren  input  1  bus read strobe, one cycle per access.
REQ-006 Port: addr  input  32  bus address; only addr[7:0] is decoded.
REQ-007 Port: wdata  input  32  bus write data.
REQ-008 Port: rdata  output  32  registered bus read data.
REQ-009 Port: rx  input  1  asynchronous serial line; idles high.

Function
REQ-010 The block SHALL implement this register map: 0x00 = read data, read-only, pops the FIFO; 0x04 = clk_div, read/write; 0x08 = status, read and write-to-clear.
REQ-011 Status SHALL be: bit0 = data available (FIFO not empty); bit1 = overrun, sticky; bit2 = framing error, sticky; bits 31:3 = 0.
REQ-012 rdata SHALL update the cycle after ren; no ren means rdata holds its value; unmapped addresses return 0.
REQ-013 A read of 0x00 SHALL return {24'b0, head byte} and pop the FIFO; when the FIFO is empty it returns 0 and does not pop.
REQ-014 A write of 0x04 SHALL load clk_div = wdata, abort any frame in progress and return the FSM to IDLE.
REQ-015 A write of 0x08 SHALL clear each status bit whose wdata bit is 1 (bit1, bit2).
REQ-016 Bit period SHALL be clk_div+1 clk cycles; the half period is (clk_div>>1)+1 cycles.
REQ-017 rx SHALL pass through a 2-flop synchronizer before any use; input-to-detect latency is 2 cycles.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 IDLE -> START on a synchronized falling edge; the counter loads the half period.
REQ-020 In START at counter expiry: if the line is low, go to DATA with count=0 and the counter loaded to a full period; if the line is high, treat it as a glitch and return to IDLE with no error.
REQ-021 In DATA at each expiry the FSM SHALL shift the sampled bit in LSB-first; after the 8th bit it goes to STOP.
REQ-022 In STOP at expiry with the line high, the FSM SHALL push the byte into the FIFO and go to IDLE.
REQ-023 In STOP at expiry with the line low, the FSM SHALL set the framing error, discard the byte, and go to IDLE only once the line is high.
REQ-024 A push into a full FIFO SHALL discard the new byte and set overrun; the FIFO contents are unchanged.
REQ-025 A simultaneous push and pop on a full FIFO SHALL succeed with no overrun.
REQ-026 A simultaneous push and pop on an empty FIFO SHALL return 0 and then hold the new byte.
REQ-027 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full and empty are derived from the pointer MSB.
REQ-028 A clear of a status bit coinciding with a new set event of that bit SHALL leave the bit set.

Reset
REQ-029 On rst the block SHALL set: clk_div=1, FSM=IDLE, counters=0, FIFO empty, status=0, rdata=0, synchronizer flops=1.
REQ-030 rst asserted mid-frame SHALL discard the partial byte and any FIFO contents; reception resumes only on a new falling edge after reset.

Structure
REQ-031 A shared package uart_pkg SHALL hold the register offsets (0x00, 0x04, 0x08), the status bit indices, and the FSM state encodings, shared with the transmitter.
REQ-032 The FIFO SHALL be a separate sub-module uart_rx_fifo (parameter DEPTH; ports push, pop, din, dout, empty, full); all other logic stays in uart_rx.

Verification
REQ-033 Scenario: clk_div=3, frame 0xA5 at 4 cycles/bit, then read 0x08 then 0x00 -> status 0x1, data 0xA5, then status 0x0.
REQ-034 Scenario: rx low pulse of 1 cycle with clk_div=7 -> no push, status 0x0, FSM back in IDLE.
REQ-035 Scenario: stop bit driven low on byte 0x3C -> status bit2 set, FIFO empty; write 0x4 to 0x08 -> status 0x0.
REQ-036 Scenario: 5 frames 0x01..0x05 with no reads -> status 0x3; reads return 0x01..0x04, then a 5th read returns 0.
REQ-037 Scenario: rst asserted during bit 4 of 0xFF -> FIFO empty; next frame 0x5A received correctly.
REQ-038 Scenario: write 0x04 = 9 mid-frame -> frame aborted, reads back 9; next frame 0xC3 at 10 cycles/bit is received.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register offsets, status bit indices and FSM states shared by the UART blocks
package uart_pkg;

    localparam logic [7:0] REG_DATA    = 8'h00;
    localparam logic [7:0] REG_CLK_DIV = 8'h04;
    localparam logic [7:0] REG_STATUS  = 8'h08;

    localparam int ST_AVAIL   = 0;
    localparam int ST_OVERRUN = 1;
    localparam int ST_FRAMING = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - received-byte FIFO; a pop in the same cycle frees room for a push when full
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
        dout    = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // On a full push+pop the write slot equals the head slot; dout was already consumed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with programmable bit period, status register and byte FIFO
module uart_rx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic        ren,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx
);

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    uart_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        stop_wait_q, stop_wait_d;
    logic [31:0] clk_div_q, clk_div_d;
    logic        ovr_q, ovr_d;
    logic        fe_q, fe_d;
    logic [31:0] rdata_q, rdata_d;

    logic [7:0]  reg_addr;
    logic        wr_div, wr_stat, rd_data;
    logic        expired;
    logic        push, pop, set_fe, set_ovr;
    logic [7:0]  fifo_dout;
    logic        fifo_empty, fifo_full;
    logic [31:0] status;

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shift_q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        stop_wait_d = stop_wait_q;
        clk_div_d   = clk_div_q;
        rdata_d     = rdata_q;
        push        = 1'b0;
        set_fe      = 1'b0;

        reg_addr = addr[7:0];
        wr_div   = wen && (reg_addr == REG_CLK_DIV);
        wr_stat  = wen && (reg_addr == REG_STATUS);
        rd_data  = ren && (reg_addr == REG_DATA);
        expired  = (cnt_q == 32'd0);

        // Counter is loaded with (period - 1) and the sample is taken when it reaches zero.
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s2_q && rx_prev_q) begin
                    state_d = S_START;
                    cnt_d   = clk_div_q >> 1;
                end
            end
            S_START: begin
                if (expired) begin
                    if (!rx_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                        cnt_d     = clk_div_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_DATA: begin
                if (expired) begin
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    cnt_d   = clk_div_q;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_STOP: begin
                if (stop_wait_q) begin
                    if (rx_s2_q) begin
                        state_d     = S_IDLE;
                        stop_wait_d = 1'b0;
                    end
                end else if (expired) begin
                    if (rx_s2_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        set_fe      = 1'b1;
                        stop_wait_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_div) begin
            clk_div_d   = wdata;
            state_d     = S_IDLE;
            cnt_d       = 32'd0;
            bit_cnt_d   = 3'd0;
            stop_wait_d = 1'b0;
            push        = 1'b0;
            set_fe      = 1'b0;
        end

        pop     = rd_data && !fifo_empty;
        set_ovr = push && fifo_full && !pop;
        ovr_d   = (ovr_q && !(wr_stat && wdata[ST_OVERRUN])) || set_ovr;
        fe_d    = (fe_q  && !(wr_stat && wdata[ST_FRAMING])) || set_fe;

        status             = 32'd0;
        status[ST_AVAIL]   = !fifo_empty;
        status[ST_OVERRUN] = ovr_q;
        status[ST_FRAMING] = fe_q;

        if (ren) begin
            unique case (reg_addr)
                REG_DATA:    rdata_d = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
                REG_CLK_DIV: rdata_d = clk_div_q;
                REG_STATUS:  rdata_d = status;
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            stop_wait_q <= 1'b0;
            clk_div_q   <= 32'd1;
            ovr_q       <= 1'b0;
            fe_q        <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            stop_wait_q <= stop_wait_d;
            clk_div_q   <= clk_div_d;
            ovr_q       <= ovr_d;
            fe_q        <= fe_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: register table, directed scenarios, random traffic
module tb_uart_rx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, wen, ren, rx;
    logic [31:0] addr, wdata, rdata;

    int vectors     = 0;
    int miscompares = 0;

    uart_rx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .ren   (ren),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .rx    (rx)
    );

    always #5 clk = ~clk;

    // Behavioural reference: a byte queue plus two sticky flags and the current divider.
    int          exp_q[$];
    bit          m_ovr, m_fe;
    logic [31:0] m_div;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[12];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        m_div = 32'd1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        case (a[7:0])
            8'h00:   r = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'd0;
            8'h04:   r = m_div;
            8'h08:   r = {29'd0, m_fe, m_ovr, exp_q.size() > 0};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wen = 1'b1;
        tick(1);
        wen = 1'b0;
        if (a[7:0] == 8'h04) m_div = d;
        if (a[7:0] == 8'h08) begin
            if (d[1]) m_ovr = 1'b0;
            if (d[2]) m_fe  = 1'b0;
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; ren = 1'b1;
        tick(1);
        ren = 1'b0;
        d = rdata;
    endtask

    task automatic rd_model(input string name, input logic [31:0] a);
        logic [31:0] e, d;
        e = model_read(a);
        bus_read(a, d);
        check(name, d, e);
    endtask

    task automatic rd_exp(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d, unused;
        unused = model_read(a);
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        int per;
        per = int'(m_div) + 1;
        rx = 1'b0;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(per);
        end
        rx = stop_ok;
        tick(per);
        rx = 1'b1;
        tick(2 * per + 4);
        if (!stop_ok) m_fe = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(int'(b));
        else m_ovr = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        rst = 1'b1; wen = 1'b0; ren = 1'b0; rx = 1'b1; addr = '0; wdata = '0;
        model_reset();
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_rdata", rdata, 32'd0);

        tbl[0]  = '{0, 32'h0000_0008, 32'h0,    32'h0};
        tbl[1]  = '{0, 32'h0000_0004, 32'h0,    32'h1};
        tbl[2]  = '{0, 32'h0000_0000, 32'h0,    32'h0};
        tbl[3]  = '{0, 32'h0000_000C, 32'h0,    32'h0};
        tbl[4]  = '{1, 32'h0000_0004, 32'h1234, 32'h0};
        tbl[5]  = '{0, 32'h0000_0004, 32'h0,    32'h1234};
        tbl[6]  = '{0, 32'hFFFF_FF04, 32'h0,    32'h1234};
        tbl[7]  = '{1, 32'h0000_0000, 32'hFF,   32'h0};
        tbl[8]  = '{0, 32'h0000_0008, 32'h0,    32'h0};
        tbl[9]  = '{1, 32'h0000_0004, 32'h3,    32'h0};
        tbl[10] = '{0, 32'h0000_0004, 32'h0,    32'h3};
        tbl[11] = '{0, 32'h0000_0010, 32'h0,    32'h0};
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].a, tbl[i].d);
            end else begin
                bus_read(tbl[i].a, d);
                check($sformatf("table[%0d]", i), d, tbl[i].exp);
            end
        end
        bus_read(32'h4, d);
        tick(6);
        check("rdata_hold", rdata, 32'h3);

        // clean 0xA5 frame at 4 cycles/bit
        send_frame(8'hA5, 1'b1);
        rd_exp("a5_status", 32'h8, 32'h1);
        rd_exp("a5_data", 32'h0, 32'hA5);
        rd_exp("a5_status_after", 32'h8, 32'h0);

        // single-cycle glitch is ignored and the receiver stays usable
        bus_write(32'h4, 32'd7);
        rx = 1'b0; tick(1); rx = 1'b1; tick(40);
        rd_exp("glitch_status", 32'h8, 32'h0);
        rd_exp("glitch_data", 32'h0, 32'h0);
        send_frame(8'h96, 1'b1);
        rd_exp("post_glitch_data", 32'h0, 32'h96);

        // framing error on 0x3C
        bus_write(32'h4, 32'd3);
        send_frame(8'h3C, 1'b0);
        rd_exp("frame_err_status", 32'h8, 32'h4);
        bus_write(32'h8, 32'h4);
        rd_exp("frame_err_cleared", 32'h8, 32'h0);

        // overrun: five frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        rd_exp("ovr_status", 32'h8, 32'h3);
        for (int i = 1; i <= 4; i++) rd_exp($sformatf("ovr_data%0d", i), 32'h0, 32'(i));
        rd_exp("ovr_data_empty", 32'h0, 32'h0);
        rd_exp("ovr_sticky", 32'h8, 32'h2);
        bus_write(32'h8, 32'h2);
        rd_exp("ovr_cleared", 32'h8, 32'h0);

        // reset during bit 4 of 0xFF, with one byte already queued
        send_frame(8'h11, 1'b1);
        rx = 1'b0; tick(4);
        rx = 1'b1; tick(4 * 4 + 2);
        rst = 1'b1; tick(1); rst = 1'b0;
        model_reset();
        tick(30);
        rd_exp("rst_status", 32'h8, 32'h0);
        rd_exp("rst_div", 32'h4, 32'h1);
        bus_write(32'h4, 32'd3);
        send_frame(8'h5A, 1'b1);
        rd_exp("rst_next_data", 32'h0, 32'h5A);

        // divider write aborts a frame in progress
        rx = 1'b0; tick(4 + 6);
        bus_write(32'h4, 32'd9);
        rx = 1'b1; tick(40);
        rd_exp("abort_div", 32'h4, 32'h9);
        rd_exp("abort_status", 32'h8, 32'h0);
        send_frame(8'hC3, 1'b1);
        rd_exp("abort_next_data", 32'h0, 32'hC3);

        // random traffic against the reference model
        bus_write(32'h4, 32'($urandom_range(3, 15)));
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_frame(8'($urandom), ($urandom_range(0, 7) != 0));
                4, 5:       rd_model("rnd_data", 32'h0);
                6:          rd_model("rnd_status", 32'h8);
                7:          bus_write(32'h8, 32'($urandom_range(0, 7)));
                8:          bus_write(32'h4, 32'($urandom_range(3, 15)));
                default:    rd_model("rnd_div", 32'h4);
            endcase
        end
        rd_model("rnd_final_status", 32'h8);
        for (int i = 0; i < DEPTH + 1; i++) rd_model("rnd_drain", 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
